// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg
//   Types shared by the shift_reg controller and the shift_reg ctrl_code decode.
//   sr_cmd_t    : 2-bit command driven on ctrl_code (UPLOAD is the idle code).
//   src_state_t : controller FSM states, also exported on the debug port.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    REG_UPLOAD = 2'd0,
    REG_LOAD   = 2'd1,
    REG_WRITE  = 2'd2,
    REG_READ   = 2'd3
  } sr_cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    FLUSH = 3'd2,
    LOAD  = 3'd3,
    DRAIN = 3'd4
  } src_state_t;

  // Depth of the drain-side FIFO; the READ credit limit equals this depth.
  localparam int SR_FIFO_DEPTH = 2;

endpackage

// File: rtl/sr_out_fifo.sv
// sr_out_fifo
//   2-entry FIFO holding words read back from the shift_reg until the drain
//   stream consumer takes them.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   push           write push_data this cycle (caller guarantees space)
//   push_data      word to store
//   pop            head consumed this cycle (only while out_valid)
//   out_valid      FIFO not empty
//   out_data       head word; 0 after reset
//   count          number of stored words (0..2)
module sr_out_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl
//   Initiator for a shift_reg on the ctrl_code interface.
//   Fill: LENGTH accepted words become LENGTH WRITE commands, then one UPLOAD;
//   frame_done pulses when the shift_reg data_out holds the frame.
//   Drain: start_read issues LOAD then LENGTH READs; the words come back out
//   as a valid/ready stream through a 2-entry FIFO.
// Handshakes: a word moves on a stream in every cycle where valid and ready
//   are both high at the rising clock edge; a valid word and its data hold
//   until taken.
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   wr_data/wr_valid/wr_ready fill stream (wr_ready is 0 outside IDLE/FILL)
//   start_read                pulse in IDLE: LOAD then drain
//   reread                    only with SHIFT_REG_CTRL_REREAD_EN: drain again, no LOAD
//   rd_data/rd_valid/rd_ready drain stream
//   ctrl_code, sr_data_write  registered command/word to the shift_reg
//   sr_data_read              shift_reg head word, sampled while READ is on ctrl_code
//   frame_done                1-cycle pulse: data_out holds the completed frame
//   busy                      FSM not in IDLE
//   dbg_state                 current FSM state
// Configuration macro: SHIFT_REG_CTRL_REREAD_EN (adds the reread input).
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  start_read,
`ifdef SHIFT_REG_CTRL_REREAD_EN
  input  logic                  reread,
`endif
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output sr_cmd_t               ctrl_code,
  output logic [DATA_WIDTH-1:0] sr_data_write,
  input  logic [DATA_WIDTH-1:0] sr_data_read,
  output logic                  frame_done,
  output logic                  busy,
  output src_state_t            dbg_state
);

  localparam int            CW      = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] LAST_WR = CW'(LENGTH - 1);
  localparam logic [CW-1:0] LEN_C   = CW'(LENGTH);

  src_state_t    state;
  logic          armed;      // keeps wr_ready low through reset and the cycle after
  logic [CW-1:0] wr_cnt;     // FILL: words accepted; FLUSH: 0/1 phase
  logic [CW-1:0] rd_cnt;     // READs issued in the current drain
  logic [1:0]    fifo_count;
  logic          fifo_pop;
  logic          capture;
  logic          credit_ok;
  logic          fifo_empties;
  logic          accept;
  logic          idle_claimed;
  logic [2:0]    occupancy;

`ifdef SHIFT_REG_CTRL_REREAD_EN
  assign idle_claimed = start_read | reread;
`else
  assign idle_claimed = start_read;
`endif

  assign wr_ready = armed & ((state == FILL) | ((state == IDLE) & ~idle_claimed));
  assign accept   = wr_valid & wr_ready;
  assign busy     = (state != IDLE);
  assign dbg_state = state;

  // The READ on ctrl_code this cycle has its word on sr_data_read now.
  assign capture  = (ctrl_code == REG_READ);
  assign fifo_pop = rd_valid & rd_ready;

  // A new READ lands in the FIFO two cycles from now. Count stored words plus
  // the READ currently on the wire, less the head leaving this cycle; staying
  // below the depth guarantees space and keeps at most 2 words ahead.
  assign occupancy = 3'(fifo_count) + 3'(capture);
  assign credit_ok = occupancy < (3'(SR_FIFO_DEPTH) + 3'(fifo_pop));

  assign fifo_empties = (fifo_count == 2'd0) | ((fifo_count == 2'd1) & fifo_pop);

  sr_out_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (capture),
    .push_data (sr_data_read),
    .pop       (fifo_pop),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      ctrl_code     <= REG_UPLOAD;
      sr_data_write <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      frame_done    <= 1'b0;
    end else begin
      armed      <= 1'b1;
      ctrl_code  <= REG_UPLOAD;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_read) begin
            state <= LOAD;
          end
`ifdef SHIFT_REG_CTRL_REREAD_EN
          else if (reread) begin
            state  <= DRAIN;
            rd_cnt <= '0;
          end
`endif
          else if (accept) begin
            ctrl_code     <= REG_WRITE;
            sr_data_write <= wr_data;
            wr_cnt        <= ONE;
            state         <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            ctrl_code     <= REG_WRITE;
            sr_data_write <= wr_data;
            if (wr_cnt == LAST_WR) begin
              wr_cnt <= '0;
              state  <= FLUSH;
            end else begin
              wr_cnt <= wr_cnt + ONE;
            end
          end
        end
        FLUSH: begin
          // Phase 0: last WRITE on the wire, UPLOAD goes out next.
          // Phase 1: UPLOAD on the wire, data_out valid next cycle.
          if (wr_cnt == '0) begin
            wr_cnt <= ONE;
          end else begin
            wr_cnt     <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        LOAD: begin
          ctrl_code <= REG_LOAD;
          rd_cnt    <= '0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if ((rd_cnt != LEN_C) && credit_ok) begin
            ctrl_code <= REG_READ;
            rd_cnt    <= rd_cnt + ONE;
          end else if ((rd_cnt == LEN_C) && !capture && fifo_empties) begin
            rd_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl
//   Bench for shift_reg_ctrl with a behavioural shift_reg (LENGTH=4, DATA_WIDTH=8).
//   Shift_reg model: WRITE shifts data_write in at the tail, READ rotates the
//   head to the tail, LOAD copies data_in, UPLOAD copies contents to data_out;
//   data_read is the current head word.
module tb_shift_reg_ctrl;
  import shift_reg_pkg::*;

  localparam int DW = 8;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          start_read = 1'b0;
`ifdef SHIFT_REG_CTRL_REREAD_EN
  logic          reread = 1'b0;
`endif
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  sr_cmd_t       ctrl_code;
  logic [DW-1:0] sr_data_write;
  logic [DW-1:0] sr_data_read;
  logic          frame_done;
  logic          busy;
  src_state_t    dbg_state;

  int n_checks = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  shift_reg_ctrl #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .start_read    (start_read),
`ifdef SHIFT_REG_CTRL_REREAD_EN
    .reread        (reread),
`endif
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .ctrl_code     (ctrl_code),
    .sr_data_write (sr_data_write),
    .sr_data_read  (sr_data_read),
    .frame_done    (frame_done),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- shift_reg model ----------------
  logic [DW-1:0] sr_mem [L];
  logic [DW-1:0] sr_out [L];
  logic [DW-1:0] sr_in  [L];

  assign sr_data_read = sr_mem[0];

  always @(posedge clk) begin
    case (ctrl_code)
      REG_UPLOAD: for (int i = 0; i < L; i++) sr_out[i] <= sr_mem[i];
      REG_LOAD:   for (int i = 0; i < L; i++) sr_mem[i] <= sr_in[i];
      REG_WRITE: begin
        for (int i = 0; i < L - 1; i++) sr_mem[i] <= sr_mem[i+1];
        sr_mem[L-1] <= sr_data_write;
      end
      REG_READ: begin
        for (int i = 0; i < L - 1; i++) sr_mem[i] <= sr_mem[i+1];
        sr_mem[L-1] <= sr_mem[0];
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  int            cyc = 0;
  logic [DW-1:0] exp_q   [$];   // words expected on the drain stream
  logic [DW-1:0] wexp_q  [$];   // accepted fill words awaiting their WRITE
  logic [31:0]   frame_q [$];   // frames expected at frame_done
  int            hs_cyc  [$];   // cycles of drain handshakes
  int            fd_due = -1;
  int            wr_seen = 0;
  int            gap_up = 0;
  int            last_gap = -1;
  logic [31:0]   cur_frame = '0;
  logic [31:0]   last_frame = '0;
  bit            prev_accept = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_rd = '0;
  int            issued = 0;
  int            taken = 0;
  int            lcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    logic [31:0]   dout;
    dout = {sr_out[0], sr_out[1], sr_out[2], sr_out[3]};
    if (!reset_n) begin
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ctrl_code", 32'(ctrl_code), 32'(REG_UPLOAD));
      chk("rst_sr_data_write", 32'(sr_data_write), 32'd0);
      exp_q.delete(); wexp_q.delete(); frame_q.delete();
      fd_due = -1; wr_seen = 0; gap_up = 0;
      prev_accept = 0; prev_stall = 0; issued = 0; taken = 0;
    end else begin
      // every accepted word becomes a WRITE of that word on the next cycle
      chk("write_follows_accept", 32'(ctrl_code == REG_WRITE), 32'(prev_accept));
      if (ctrl_code == REG_WRITE) begin
        if (wexp_q.size() == 0) begin
          chk("write_unexpected", 32'd1, 32'd0);
        end else begin
          w = wexp_q.pop_front();
          chk("write_data", 32'(sr_data_write), 32'(w));
          cur_frame = {cur_frame[23:0], w};
          wr_seen++;
          if (wr_seen == L) begin
            frame_q.push_back(cur_frame);
            fd_due   = cyc + 2;
            last_gap = gap_up;
            wr_seen  = 0;
            gap_up   = 0;
          end
        end
      end else if (wr_seen != 0 && ctrl_code == REG_UPLOAD) begin
        gap_up++;
      end
      chk("frame_done_timing", 32'(frame_done), 32'(cyc == fd_due));
      if (frame_done) begin
        last_frame = dout;
        if (frame_q.size() != 0) chk("frame_data", dout, frame_q.pop_front());
      end
      if (ctrl_code == REG_LOAD || ctrl_code == REG_READ)
        chk("wr_ready_low_in_drain", 32'(wr_ready), 32'd0);
      if (ctrl_code == REG_LOAD) lcnt++;
      if (ctrl_code == REG_READ) issued++;
      chk("reads_ahead_le2", 32'((issued - taken) <= 2), 32'd1);
      if (prev_stall) begin
        chk("rd_hold_valid", 32'(rd_valid), 32'd1);
        chk("rd_hold_data", 32'(rd_data), 32'(prev_rd));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        taken++;
        hs_cyc.push_back(cyc);
      end
      prev_stall  = rd_valid && !rd_ready;
      prev_rd     = rd_data;
      prev_accept = wr_valid && wr_ready;
      if (wr_valid && wr_ready) wexp_q.push_back(wr_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_falls", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int t = 0;
    wr_valid = 1'b1;
    wr_data  = w;
    @(negedge clk);
    while (!wr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wr_ready_seen", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic fill(input logic [31:0] frame, input bit gaps);
    for (int i = 0; i < L; i++) begin
      send_word(frame[31-8*i -: 8]);
      if (gaps && i != L - 1) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
  endtask

  task automatic drain(input logic [31:0] frame, input bit use_reread, input bit stall);
    int base;
    int t = 0;
    hs_cyc.delete();
    for (int i = 0; i < L; i++) begin
      if (!use_reread) sr_in[i] = frame[31-8*i -: 8];
      exp_q.push_back(frame[31-8*i -: 8]);
    end
    base = taken;
    rd_ready = 1'b1;
`ifdef SHIFT_REG_CTRL_REREAD_EN
    if (use_reread) reread = 1'b1;
    else start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    reread = 1'b0;
`else
    start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
`endif
    if (stall) begin
      while (taken < base + 2 && t < 100) begin
        @(posedge clk);
        t++;
      end
      #1;
      chk("stall_point_reached", 32'(taken >= base + 2), 32'd1);
      rd_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rd_ready = 1'b1;
    end
    wait_idle();
    chk("drain_all_words", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lc0;
    int base;
    int t;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // back-to-back fill
    last_frame = '0;
    fill(32'h11223344, 1'b0);
    chk("fill_b2b_data_out", last_frame, 32'h11223344);
    chk("fill_b2b_gaps", 32'(last_gap), 32'd0);

    // fill with a gap after every word: one UPLOAD per gap
    last_frame = '0;
    fill(32'h11223344, 1'b1);
    chk("fill_gap_data_out", last_frame, 32'h11223344);
    chk("fill_gap_uploads", 32'(last_gap), 32'd3);

    // full-rate drain
    lc0 = lcnt;
    drain(32'hA0A1A2A3, 1'b0, 1'b0);
    chk("drain_one_load", 32'(lcnt - lc0), 32'd1);
    chk("drain_hs_count", 32'(hs_cyc.size()), 32'd4);
    if (hs_cyc.size() == 4) chk("drain_consecutive", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);

`ifdef SHIFT_REG_CTRL_REREAD_EN
    // same frame again without LOAD
    lc0 = lcnt;
    drain(32'hA0A1A2A3, 1'b1, 1'b0);
    chk("reread_no_load", 32'(lcnt - lc0), 32'd0);
    chk("reread_hs_count", 32'(hs_cyc.size()), 32'd4);
`endif

    // consumer stalls 5 cycles mid-stream
    drain(32'hB0B1B2B3, 1'b0, 1'b1);
    chk("stall_hs_count", 32'(hs_cyc.size()), 32'd4);

    // start_read and wr_valid together in IDLE
    for (int i = 0; i < L; i++) begin
      sr_in[i] = 8'hC0 + 8'(i);
      exp_q.push_back(8'hC0 + 8'(i));
    end
    lc0 = lcnt;
    wr_valid = 1'b1;
    wr_data = 8'h99;
    start_read = 1'b1;
    @(negedge clk);
    chk("collide_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    start_read = 1'b0;
    wr_valid = 1'b0;
    wait_idle();
    chk("collide_one_load", 32'(lcnt - lc0), 32'd1);
    chk("collide_all_words", 32'(exp_q.size()), 32'd0);

    // reset during drain after two words
    for (int i = 0; i < L; i++) begin
      sr_in[i] = 8'hD0 + 8'(i);
      exp_q.push_back(8'hD0 + 8'(i));
    end
    base = taken;
    start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    t = 0;
    while (taken < base + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("reset_point_reached", 32'(taken >= base + 2), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rst_rd_data", 32'(rd_data), 32'd0);
    chk("async_rst_ctrl_code", 32'(ctrl_code), 32'(REG_UPLOAD));
    chk("async_rst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    last_frame = '0;
    fill(32'h5AC30FF0, 1'b0);
    chk("post_reset_data_out", last_frame, 32'h5AC30FF0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
